// File: rtl/deser_pkg.sv
// Shared definitions for the receive-side deserializer.
//   deser_state_e     : alignment state (HUNT, CONFIRM, LOCKED)
//   SYNC_WORD_DEFAULT : alignment pattern, also used by the transmit-side sync inserter
package deser_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } deser_state_e;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hF0A5;

endpackage

// File: rtl/deser_sync_fsm.sv
// Word-alignment state machine for deserializer_to.
// Tracks the consecutive-sync-word count needed to declare lock and a watchdog counting
// non-sync words while locked.
// Ports:
//   clk        : bit clock
//   reset      : asynchronous, active-high
//   wc_i       : word-completion edge (bit counter at WIDTH-1)
//   match_i    : the word completing on this edge equals the sync word
//   realign_i  : force return to HUNT (highest priority)
//   state_o    : current alignment state
//   lost_o     : registered 1-cycle pulse when the watchdog drops lock
module deser_sync_fsm
  import deser_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 3,
  parameter int unsigned SYNC_PERIOD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wc_i,
  input  logic         match_i,
  input  logic         realign_i,
  output deser_state_e state_o,
  output logic         lost_o
);

  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WdW   = $clog2(SYNC_PERIOD + 1);

  localparam logic [GoodW-1:0] GoodLock = GoodW'(LOCK_CNT);
  localparam logic [WdW-1:0]   WdTrip   = WdW'(SYNC_PERIOD);

  deser_state_e     state_q, state_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             lost_q, lost_d;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    wd_d    = wd_q;
    lost_d  = 1'b0;
    if (realign_i) begin
      state_d = HUNT;
      good_d  = '0;
      wd_d    = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          // Any bit offset may match here; the top re-phases the bit counter.
          if (match_i) begin
            good_d = GoodW'(1);
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              wd_d    = '0;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (wc_i) begin
            if (match_i) begin
              good_d = good_q + 1'b1;
              if (good_q + 1'b1 == GoodLock) begin
                state_d = LOCKED;
                wd_d    = '0;
              end
            end else begin
              state_d = HUNT;
              good_d  = '0;
            end
          end
        end
        LOCKED: begin
          if (wc_i) begin
            if (match_i) begin
              wd_d = '0;
            end else if (wd_q + 1'b1 == WdTrip) begin
              state_d = HUNT;
              lost_d  = 1'b1;
              wd_d    = '0;
              good_d  = '0;
            end else begin
              wd_d = wd_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          good_d  = '0;
          wd_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      good_q  <= '0;
      wd_q    <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      wd_q    <= wd_d;
      lost_q  <= lost_d;
    end
  end

  assign state_o = state_q;
  assign lost_o  = lost_q;

endmodule

// File: rtl/deserializer_to.sv
// Receive-side 1:WIDTH deserializer. Shifts in one serial bit (MSB first) per clock, hunts for
// SYNC_WORD at any bit offset, confirms lock over LOCK_CNT consecutive aligned sync words, then
// emits aligned words with a 1-cycle valid strobe. A watchdog drops lock after SYNC_PERIOD
// consecutive non-sync words.
// Ports:
//   clk        : bit clock, one serial bit sampled per rising edge
//   reset      : asynchronous, active-high
//   data_i     : serial data bit
//   realign_i  : force return to HUNT on the next edge
//   data_o     : aligned word (registered)
//   valid_o    : 1-cycle strobe, data_o updated this cycle
//   sync_o     : qualifies valid_o, data_o equals SYNC_WORD
//   lock_o     : high while locked
//   lost_o     : 1-cycle pulse when the watchdog drops lock
module deserializer_to
  import deser_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      LOGWIDTH    = 4,
  parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(SYNC_WORD_DEFAULT),
  parameter int unsigned      LOCK_CNT    = 3,
  parameter int unsigned      SYNC_PERIOD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_i,
  input  logic             realign_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             sync_o,
  output logic             lock_o,
  output logic             lost_o
);

  // Only the low WIDTH-1 bits of the shift history are ever read: the word under test is
  // always {history, data_i}, so the oldest bit would be discarded before use.
  logic [WIDTH-2:0]    sr_q, sr_d;
  logic [LOGWIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                sync_q, sync_d;

  logic [WIDTH-1:0] word_nx;
  logic             wc;
  logic             match;
  deser_state_e     state;

  assign word_nx = {sr_q, data_i};
  assign wc      = (cnt_q == LOGWIDTH'(WIDTH - 1));
  assign match   = (word_nx == SYNC_WORD);

  deser_sync_fsm #(
    .LOCK_CNT    (LOCK_CNT),
    .SYNC_PERIOD (SYNC_PERIOD)
  ) u_sync_fsm (
    .clk       (clk),
    .reset     (reset),
    .wc_i      (wc),
    .match_i   (match),
    .realign_i (realign_i),
    .state_o   (state),
    .lost_o    (lost_o)
  );

  always_comb begin
    sr_d    = word_nx[WIDTH-2:0];
    cnt_d   = wc ? '0 : cnt_q + 1'b1;
    data_d  = data_q;
    valid_d = 1'b0;
    sync_d  = 1'b0;

    // A sync hit while hunting re-phases the counter so the next word completes WIDTH edges on.
    if (realign_i || (state == HUNT && match)) begin
      cnt_d = '0;
    end

    if (state == LOCKED && wc && !realign_i) begin
      data_d  = word_nx;
      valid_d = 1'b1;
      sync_d  = match;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sync_o  = sync_q;
  assign lock_o  = (state == LOCKED);

endmodule
